// File: rtl/lix_pkg.sv
// lix_pkg: shared widths, skid depth and counter sizing for the lix pipeline slice
package lix_pkg;
  localparam int LIX_W = 32;
  localparam int LIX_N = 2;
  localparam int LIX_SKID_DEPTH = 2;
  typedef logic [$clog2(LIX_SKID_DEPTH+1)-1:0] lix_occ_t;
  function automatic int lix_cntw(input int n);
    return $clog2(n + 3);
  endfunction
endpackage

// File: rtl/lix_reg.sv
// lix_reg: enable-only pipeline register with async active-low clear
module lix_reg #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= '0;
    else if (en_i) q_o <= d_i;
  end
endmodule

// File: rtl/lix_skid.sv
// lix_skid: 2-entry output FIFO; flush clears occupancy but leaves stored data
module lix_skid import lix_pkg::*; #(
  parameter int W = LIX_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output lix_occ_t     occ_o
);
  logic [W-1:0] mem_q [LIX_SKID_DEPTH];
  logic         wp_q, rp_q, do_pop;
  lix_occ_t     occ_q;
  assign do_pop = pop_i & (occ_q != '0);
  assign data_o = mem_q[rp_q];
  assign occ_o  = occ_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= '0;
    end else if (flush_i) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= '0;
    end else begin
      if (push_i) mem_q[wp_q] <= data_i;
      wp_q  <= wp_q ^ push_i;
      rp_q  <= rp_q ^ do_pop;
      occ_q <= occ_q + lix_occ_t'(push_i) - lix_occ_t'(do_pop);
    end
  end
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !do_pop && occ_q == lix_occ_t'(LIX_SKID_DEPTH)));
endmodule

// File: rtl/lix_pipe_ctl.sv
// lix_pipe_ctl: valid/ready controller driving a global stage enable for aligned share lanes.
// Define LIX_SKID_EN for a 2-entry output skid with registered ready (no m_rdy->s_rdy path).
module lix_pipe_ctl import lix_pkg::*; #(
  parameter int W = LIX_W,
  parameter int N = LIX_N
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_flush,
  input  logic                   s_vld,
  output logic                   s_rdy,
  input  logic [W-1:0]           s_x,
  output logic                   m_vld,
  input  logic                   m_rdy,
  output logic [W-1:0]           m_z,
  output logic                   o_en,
  output logic                   o_vld,
  output logic [lix_cntw(N)-1:0] o_cnt
);
  localparam int CW = lix_cntw(N);
  logic [N-1:0] v, v_in;
  logic [W-1:0] d [N];
  logic [W-1:0] d_in [N];
  lix_occ_t     occ;
  assign s_rdy = o_en;
  assign o_vld = s_vld & s_rdy & ~i_flush & rst_ni;
  always_comb begin
    v_in = (v << 1) | N'(o_vld);
    d_in[0] = s_x;
    for (int i = 1; i < N; i++) d_in[i] = d[i-1];
  end
  // valids follow the enable (flush forces a clear); data only loads behind a valid
  for (genvar k = 0; k < N; k++) begin : g_stg
    lix_reg #(.W(1)) u_v (
      .clk_i, .rst_ni, .en_i(o_en | i_flush), .d_i(v_in[k] & ~i_flush), .q_o(v[k])
    );
    lix_reg #(.W(W)) u_d (
      .clk_i, .rst_ni, .en_i(o_en & v_in[k] & ~i_flush), .d_i(d_in[k]), .q_o(d[k])
    );
  end
`ifdef LIX_SKID_EN
  logic     en_q, en_d, push, pop;
  lix_occ_t occ_d;
  assign push  = en_q & v[N-1];
  assign pop   = m_vld & m_rdy;
  assign occ_d = i_flush ? '0 : occ + lix_occ_t'(push) - lix_occ_t'(pop);
  assign en_d  = occ_d <= lix_occ_t'(1);
  assign o_en  = en_q;
  assign m_vld = occ != '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) en_q <= 1'b1;
    else en_q <= en_d;
  end
  lix_skid #(.W(W)) u_skid (
    .clk_i, .rst_ni, .flush_i(i_flush), .push_i(push), .pop_i(pop),
    .data_i(d[N-1]), .data_o(m_z), .occ_o(occ)
  );
`else
  assign o_en  = ~v[N-1] | m_rdy;
  assign m_vld = v[N-1];
  assign m_z   = d[N-1];
  assign occ   = '0;
`endif
  always_comb begin
    o_cnt = CW'(occ);
    for (int i = 0; i < N; i++) o_cnt += CW'(v[i]);
  end
endmodule

// File: tb/tb_lix_pipe_ctl.sv
// tb_lix_pipe_ctl: directed vectors plus queue scoreboard for lix_pipe_ctl (W=8, N=2)
module tb_lix_pipe_ctl;
  localparam int W = 8;
  localparam int N = 2;
`ifdef LIX_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif
  localparam int LAT = N + SKID;
  logic         clk_i, rst_ni, i_flush, s_vld, s_rdy, m_vld, m_rdy, o_en, o_vld;
  logic [W-1:0] s_x, m_z, held;
  logic [2:0]   o_cnt;
  logic [W-1:0] q [$];
  int           n_chk = 0, n_err = 0, idx;

  lix_pipe_ctl #(.W(W), .N(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_flush(i_flush), .s_vld(s_vld), .s_rdy(s_rdy),
    .s_x(s_x), .m_vld(m_vld), .m_rdy(m_rdy), .m_z(m_z), .o_en(o_en), .o_vld(o_vld),
    .o_cnt(o_cnt)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // scoreboard: queue holds every accepted item not yet delivered
  always @(negedge clk_i) begin
    if (!rst_ni) q.delete();
    else begin
      chk("cnt_model", 32'(o_cnt), 32'(q.size()));
      if (m_vld && m_rdy) begin
        if (q.size() == 0) chk("sb_unexpected", 32'(q.size()), 1);
        else chk("sb_data", 32'(m_z), 32'(q.pop_front()));
      end
      if (s_vld && s_rdy && !i_flush) q.push_back(s_x);
      if (i_flush) q.delete();
    end
  end

  initial begin
    rst_ni = 1'b0; i_flush = 1'b0; s_vld = 1'b1; s_x = 8'h55; m_rdy = 1'b1;
    #13;
    chk("rst_srdy", 32'(s_rdy), 1);
    chk("rst_oen", 32'(o_en), 1);
    chk("rst_mvld", 32'(m_vld), 0);
    chk("rst_ovld", 32'(o_vld), 0);
    chk("rst_cnt", 32'(o_cnt), 0);
    chk("rst_mz", 32'(m_z), 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1; s_vld = 1'b0;
    cyc();
    // streaming at full rate
    for (int c = 0; c < 9 + LAT; c++) begin
      s_vld = c < 8; s_x = 8'(8'h11 + c); m_rdy = 1'b1;
      #2;
      if (c == LAT - 1) chk("strm_lat_pre", 32'(m_vld), 0);
      if (c >= LAT && c < LAT + 8) begin
        chk("strm_mvld", 32'(m_vld), 1);
        chk("strm_mz", 32'(m_z), 32'(8'h11 + c - LAT));
      end
      if (c >= LAT && c < 8) chk("strm_cnt", 32'(o_cnt), LAT);
      cyc();
    end
    // downstream stall mid-stream
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      s_vld = idx < 6; s_x = 8'(8'hA0 + idx); m_rdy = !(c >= 3 && c <= 6);
      #2;
      if (c == 3) begin
        chk("stall_srdy_c3", 32'(s_rdy), SKID);
        held = m_z;
      end
      if (c == 4) chk("stall_srdy_c4", 32'(s_rdy), 0);
      if (c >= 4 && c <= 6) begin
        chk("stall_mvld", 32'(m_vld), 1);
        chk("stall_mz", 32'(m_z), 32'(held));
      end
      if (s_vld && s_rdy) idx++;
      cyc();
    end
    chk("stall_sent", idx, 6);
    s_vld = 1'b0; m_rdy = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    chk("stall_drain", 32'(q.size()), 0);
    // flush with two items in flight
    for (int c = 0; c < 2; c++) begin
      s_vld = 1'b1; s_x = 8'(8'h21 + c); m_rdy = 1'b0;
      cyc();
    end
    i_flush = 1'b1; s_x = 8'hFF;
    #2;
    chk("flush_cnt_pre", 32'(o_cnt), 2);
    chk("flush_ovld", 32'(o_vld), 0);
    cyc();
    i_flush = 1'b0; s_vld = 1'b0; m_rdy = 1'b1;
    #2;
    chk("flush_cnt", 32'(o_cnt), 0);
    chk("flush_mvld", 32'(m_vld), 0);
    for (int c = 0; c < 4; c++) begin
      chk("flush_no_ff", 32'(m_vld && m_z == 8'hFF), 0);
      cyc();
      #2;
    end
    cyc();
    // single item followed by bubbles with toggling data
    for (int c = 0; c < LAT + 3; c++) begin
      s_vld = c == 0; m_rdy = 1'b1;
      s_x = c == 0 ? 8'h5A : (c[0] ? 8'hFF : 8'h00);
      #2;
      chk("bub_ovld", 32'(o_vld), 32'(c == 0));
      chk("bub_oen", 32'(o_en), 1);
      if (c == LAT) chk("bub_mvld", 32'(m_vld), 1);
      if (c >= LAT && (SKID == 0 || c == LAT)) chk("bub_mz", 32'(m_z), 8'h5A);
      cyc();
    end
    // async reset while stalled with output full
    for (int c = 0; c < 6; c++) begin
      s_vld = 1'b1; s_x = 8'(8'h40 + c); m_rdy = 1'b0;
      cyc();
    end
    s_vld = 1'b0;
    #2;
    chk("prerst_mvld", 32'(m_vld), 1);
    rst_ni = 1'b0;
    #1;
    chk("arst_mvld", 32'(m_vld), 0);
    chk("arst_cnt", 32'(o_cnt), 0);
    chk("arst_srdy", 32'(s_rdy), 1);
    cyc();
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    cyc();
    for (int c = 0; c <= LAT; c++) begin
      s_vld = c == 0; s_x = 8'h33; m_rdy = 1'b1;
      #2;
      if (c == LAT - 1) chk("post_rst_pre", 32'(m_vld), 0);
      if (c == LAT) begin
        chk("post_rst_mvld", 32'(m_vld), 1);
        chk("post_rst_mz", 32'(m_z), 8'h33);
      end
      cyc();
    end
    // random traffic checked by the scoreboard
    for (int c = 0; c < 10000; c++) begin
      s_vld = 1'($urandom_range(0, 1)); m_rdy = 1'($urandom_range(0, 1)); s_x = 8'($urandom);
      cyc();
    end
    s_vld = 1'b0; m_rdy = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    chk("rand_drain", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lix_pipe_ctl.md
# lix_pipe_ctl

N-stage, W-bit valid/ready pipeline controller that wraps the enable-only shift-register stages with a backpressure-capable handshake. It sits directly upstream of the fixed-latency share pipelines in the A2B datapath. It generates the global stage enable (o_en) and the entry valid (o_vld) that sibling share lanes consume, and it carries one W-bit lane itself. A downstream stall freezes every stage, so all share lanes stay aligned cycle-for-cycle.

## Interface
- W, default 32: lane data width in bits
- N, default 2: pipeline depth in stages, N ≥ 1
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- i_flush  in  1  synchronous clear of all in-flight valids
- s_vld  in  1  upstream data valid
- s_rdy  out  1  upstream ready
- s_x  in  W  upstream data
- m_vld  out  1  downstream data valid
- m_rdy  in  1  downstream ready
- m_z  out  W  downstream data
- o_en  out  1  stage enable exported to sibling lanes; same signal that clocks this lane's stages
- o_vld  out  1  entry valid for sibling lanes: s_vld & s_rdy & ~i_flush
- o_cnt  out  $clog2(N+3)  items in flight (stages plus skid)

## Operation
- Stage valid chain v[0..N-1] and data regs d[0..N-1].
  - On o_en: v[0] <= o_vld, v[k] <= v[k-1].
  - d[k] loads only when o_en and its incoming valid are both 1. Bubbles do not toggle data (power and SCA hygiene).
- Transfer at the input is s_vld & s_rdy.
- Transfer at the output is m_vld & m_rdy.
- Without skid, o_en = ~v[N-1] | m_rdy, s_rdy = o_en, m_vld = v[N-1], m_z = d[N-1]. This is a global stall with no bubble collapse.
- i_flush has top priority:
  - Next cycle, all v and skid entries are 0 and o_cnt is 0.
  - Input presented in the flush cycle is dropped; o_vld is 0.
  - Data regs keep their values.
- o_cnt = popcount(v) + skid occupancy, updated every cycle.
  - Simultaneous push and pop leaves it unchanged.
  - It never exceeds N+2.
- Data values pass unmodified. No arithmetic is performed on the lane.

## Timing
- Reset values: v=0, d=0, skid empty, m_vld=0, m_z=0, o_cnt=0, o_vld=0.
  - s_rdy=1 and o_en=1.
  - These hold combinationally while rst_ni is low.
- Latency is N cycles without skid and N+1 cycles with skid, from input transfer to m_vld.
- Throughput is 1 item per cycle while m_rdy=1.
- Stall: with m_rdy=0 and the output holding valid data, all v and d are frozen. m_z is stable and m_vld stays 1 until the transfer.
- Reset asserted mid-operation discards all in-flight data immediately.

## Configuration
- LIX_SKID_EN defined: a 2-entry output skid buffer is inserted after stage N-1.
  - o_en becomes registered: en_q <= (skid_occ_next ≤ 1), reset value 1; s_rdy = o_en = en_q.
  - m_rdy therefore has no combinational path to s_rdy or o_en.
  - The tail pushes into the skid when en_q & v[N-1].
  - m_vld = skid_occ≠0 and m_z = skid head (FIFO order).
  - Occupancy never exceeds 2. Overflow is an assertion failure.
- LIX_SKID_EN undefined: no skid and fully combinational ready, as in Operation.

## Structure
- lix_pkg holds:
  - the default widths
  - LIX_SKID_DEPTH = 2
  - the function lix_cntw(N) = $clog2(N+3) for o_cnt sizing
- One sub-module: lix_skid, a 2-entry FIFO with push, pop, flush and occ outputs. It is instantiated only under LIX_SKID_EN.
- Stages are reused from the existing lix_reg, one instance per stage for data and one for valid.

## Test plan
- Reset, then hold s_vld=1 and m_rdy=1 with s_x=0x11,0x12,…,0x18 (N=2).
  - m_z must show 0x11..0x18 on consecutive cycles.
  - First m_vld appears 2 cycles after the first transfer, or 3 with LIX_SKID_EN.
  - o_cnt stays at 2 (3 with skid).
- Stream 0xA0..0xA5 while dropping m_rdy for 4 cycles mid-stream.
  - No item is lost or duplicated, m_z is stable during the stall, and order is preserved.
  - Without skid, s_rdy falls in the same cycle as m_rdy. With skid, s_rdy falls one cycle later.
- Assert i_flush with 2 items in flight and s_vld=1, s_x=0xFF.
  - Next cycle o_cnt=0 and m_vld=0.
  - 0xFF never appears on m_z.
- Send one item 0x5A, then idle 3 cycles.
  - o_vld pulses for 1 cycle and o_en stays 1.
  - d does not change in the bubble cycles; check by toggling s_x with s_vld=0.
- Pulse rst_ni low mid-stall with the output full.
  - m_vld=0, o_cnt=0 and s_rdy=1 immediately, asynchronously.
  - After release, a fresh item 0x33 arrives at the nominal latency.
- Random s_vld/m_rdy at 50% density for 10k cycles with a scoreboard.
  - Order is exact and o_cnt matches the reference model.
  - Under LIX_SKID_EN, the skid-overflow assertion never fires.
